// File: rtl/gp_rf_pkg.sv
// Shared types, default sizes and helpers for the register file slice.
package gp_rf_pkg;

  localparam int RF_DATA_W  = 32;
  localparam int RF_NREGS   = 32;

  // Widest write-port count the priority helper handles.
  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = 3;

  typedef logic [MAX_PORTS-1:0] port_mask_t;

  typedef struct packed {
    logic                  hit;
    logic [PORT_IDX_W-1:0] idx;
  } port_pick_t;

  // Address width for a register count.
  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

  // Highest-index set bit of a per-port match mask. The last port that matches
  // wins, which gives both write priority and bypass priority.
  function automatic port_pick_t hi_match(input port_mask_t hits);
    port_pick_t p;
    p.hit = 1'b0;
    p.idx = '0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (hits[k]) begin
        p.hit = 1'b1;
        p.idx = PORT_IDX_W'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/gp_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback, set wins.
module gp_scoreboard
  import gp_rf_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [NWR-1:0]    wr_live,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic             iss_live;

  assign iss_live = iss_en && !stall && !((ZERO_REG != 0) && (iss_addr == '0));
  assign busy_vec = busy_q;

  // Next busy state: clear on any live writeback, then apply the issue on top.
  always_comb begin
    port_mask_t hits;
    port_pick_t pick;
    // NOTE: every output of a combinational block gets a value before any
    // conditional update; a path that leaves one unassigned infers a latch.
    busy_nxt = busy_q;
    hits     = '0;
    pick     = '0;
    for (int a = 0; a < NREGS; a++) begin
      hits = '0;
      for (int j = 0; j < NWR; j++) begin
        hits[j] = wr_live[j] && (wr_addr[j*AW +: AW] == AW'(a));
      end
      pick = hi_match(hits);
      if (pick.hit) busy_nxt[a] = 1'b0;
    end
    // A new producer supersedes the one writing back this cycle.
    if (iss_live) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Busy register: synchronous clear, holds during stall.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset)       busy_q <= '0;
    else if (!stall) busy_q <= busy_nxt;
  end

endmodule

// File: rtl/gp_regfile_sb.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
module gp_regfile_sb
  import gp_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic [NREGS-1:0]      busy_vec
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NWR-1:0]    wr_live;

  // A write port only commits or bypasses when enabled, not stalled, and not
  // aimed at a hardwired zero register.
  always_comb begin
    wr_live = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_live[j] = wr_en[j] && !stall &&
                   !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end
  end

  // Data array: clear on reset, otherwise commit live writes, last port wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is cleared explicitly because software relies on
      // reading zeros after reset; this keeps it out of plain RAM macros.
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_live[j]) regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Read ports: bypass from the highest live matching write port, else array.
  always_comb begin
    logic [AW-1:0] ra;
    port_mask_t    hits;
    port_pick_t    pick;
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    hits    = '0;
    pick    = '0;
    for (int i = 0; i < NRD; i++) begin
      ra   = rd_addr[i*AW +: AW];
      hits = '0;
      for (int j = 0; j < NWR; j++) begin
        hits[j] = wr_live[j] && (wr_addr[j*AW +: AW] == ra);
      end
      pick = hi_match(hits);
      if (pick.hit) rd_data[i*DATA_W +: DATA_W] = wr_data[int'(pick.idx)*DATA_W +: DATA_W];
      else          rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
      if ((ZERO_REG != 0) && (ra == '0)) rd_data[i*DATA_W +: DATA_W] = '0;
      // A writeback landing this cycle already resolves the hazard.
      rd_busy[i] = busy_vec[ra] && !pick.hit;
    end
  end

  gp_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .wr_live  (wr_live),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

endmodule
